// File: rtl/ie_fetch_sequencer_pkg.sv
// Shared types for the execute-side fetch sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ie_fetch_sequencer_pkg;

    localparam int PC_W     = 16;
    localparam int OP_W     = 8;
    localparam int ALU_OP_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH,
        DISPATCH
    } seq_state_t;

    // Decoded instruction as handed to the execute datapath.
    typedef struct packed {
        logic [OP_W-1:0]     op;
        logic [ALU_OP_W-1:0] alu_op;
        logic [PC_W-1:0]     addr;
        logic                imm_mode;
        logic [2:0]          store_flag;
        logic [1:0]          reg_load_flag;
        logic                mem_load_flag;
    } ex_instr_t;

endpackage

// File: rtl/ie_fetch_sequencer_watchdog.sv
// Fetch watchdog: counts cycles spent waiting on instr_fetch.
// Latency: timeout is combinational on the cycle the count reaches TIMEOUT_CYCLES.
// Backpressure: none; clear has priority over enable, count saturates at the limit.
module ie_fetch_sequencer_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Timeout fires on the enabled cycle that would make the count reach the limit.
    assign timeout = en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Next count: clear wins, otherwise step while enabled and not yet expired.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !timeout) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ie_fetch_sequencer.sv
// Execute-side fetch sequencer: owns the PC, handshakes instr_fetch, dispatches decoded ops.
// Latency: ISSUE to ex_valid is 3 cycles minimum; one instruction per 4 cycles plus fetch latency.
// Backpressure: ex_valid/ex_* hold until ex_ready; no new fetch is issued while an op is pending.
module ie_fetch_sequencer
    import ie_fetch_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC       = 16'h0100,
    parameter int              TIMEOUT_CYCLES = 64,
    parameter int              CNT_W          = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [PC_W-1:0]     if_pc_to_ie,
    input  logic [PC_W-1:0]     if_addr_to_ie,
    input  logic [OP_W-1:0]     if_new_op,
    input  logic [ALU_OP_W-1:0] if_alu_op,
    input  logic                if_imm_mode,
    input  logic [2:0]          if_store_flag,
    input  logic [1:0]          if_reg_load_flag,
    input  logic                if_mem_load_flag,
    input  logic                if_instr_valid,
    output logic                ie_ready,
    output logic [PC_W-1:0]     pc_from_ie,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [OP_W-1:0]     ex_op,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [PC_W-1:0]     ex_addr,
    output logic                ex_imm_mode,
    output logic [2:0]          ex_store_flag,
    output logic [1:0]          ex_reg_load_flag,
    output logic                ex_mem_load_flag,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic                fetch_err,
    output logic [CNT_W-1:0]    instr_count
);

    seq_state_t       state_q,      state_d;
    logic [PC_W-1:0]  pc_q,         pc_d;
    logic [PC_W-1:0]  next_pc_q,    next_pc_d;
    ex_instr_t        ex_q,         ex_d;
    logic             ex_valid_q,   ex_valid_d;
    logic             ie_ready_q,   ie_ready_d;
    logic             fetch_err_q,  fetch_err_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             redir_pend_q, redir_pend_d;
    logic [PC_W-1:0]  redir_pc_q,   redir_pc_d;

    logic wd_clr;
    logic wd_en;
    logic wd_timeout;
    logic handshake;

    // The watchdog restarts on every issue and again when fetch drops valid,
    // so each wait phase gets its own full budget.
    assign wd_clr = (state_q == ISSUE) ||
                    ((state_q == WAIT_LOW) && !if_instr_valid);
    assign wd_en  = ((state_q == WAIT_LOW)  &&  if_instr_valid) ||
                    ((state_q == WAIT_HIGH) && !if_instr_valid);

    assign handshake = (state_q == DISPATCH) && ex_valid_q && ex_ready;

    ie_fetch_sequencer_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .timeout (wd_timeout)
    );

    // Next-state, PC selection, redirect capture and dispatch bookkeeping.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        next_pc_d    = next_pc_q;
        ex_d         = ex_q;
        ex_valid_d   = ex_valid_q;
        fetch_err_d  = fetch_err_q;
        cnt_d        = cnt_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;

        // A redirect seen outside IDLE is parked until the next PC update;
        // a newer redirect simply replaces an older one.
        if (redirect_valid) begin
            redir_pend_d = 1'b1;
            redir_pc_d   = redirect_pc;
        end

        case (state_q)
            IDLE: begin
                // Nothing in flight, so the redirect can land on the PC at once.
                if (redirect_valid) begin
                    pc_d         = redirect_pc;
                    redir_pend_d = 1'b0;
                end
                if (run) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!if_instr_valid) begin
                    state_d = WAIT_HIGH;
                end else if (wd_timeout) begin
                    fetch_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            WAIT_HIGH: begin
                if (if_instr_valid) begin
                    ex_d.op            = if_new_op;
                    ex_d.alu_op        = if_alu_op;
                    ex_d.addr          = if_addr_to_ie;
                    ex_d.imm_mode      = if_imm_mode;
                    ex_d.store_flag    = if_store_flag;
                    ex_d.reg_load_flag = if_reg_load_flag;
                    ex_d.mem_load_flag = if_mem_load_flag;
                    next_pc_d          = if_pc_to_ie;
                    ex_valid_d         = 1'b1;
                    state_d            = DISPATCH;
                end else if (wd_timeout) begin
                    fetch_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            DISPATCH: begin
                if (handshake) begin
                    ex_valid_d   = 1'b0;
                    // A redirect on this very edge beats an older parked one.
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end else if (redir_pend_q) begin
                        pc_d = redir_pc_q;
                    end else begin
                        pc_d = next_pc_q;
                    end
                    redir_pend_d = 1'b0;
                    cnt_d        = cnt_q + CNT_W'(1);
                    state_d      = run ? ISSUE : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // ie_ready is registered and high for exactly the ISSUE cycle.
        ie_ready_d = (state_d == ISSUE);
    end

    // All sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            next_pc_q    <= '0;
            ex_q         <= '0;
            ex_valid_q   <= 1'b0;
            ie_ready_q   <= 1'b0;
            fetch_err_q  <= 1'b0;
            cnt_q        <= '0;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            next_pc_q    <= next_pc_d;
            ex_q         <= ex_d;
            ex_valid_q   <= ex_valid_d;
            ie_ready_q   <= ie_ready_d;
            fetch_err_q  <= fetch_err_d;
            cnt_q        <= cnt_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
        end
    end

    assign ie_ready         = ie_ready_q;
    assign pc_from_ie       = pc_q;
    assign ex_valid         = ex_valid_q;
    assign ex_op            = ex_q.op;
    assign ex_alu_op        = ex_q.alu_op;
    assign ex_addr          = ex_q.addr;
    assign ex_imm_mode      = ex_q.imm_mode;
    assign ex_store_flag    = ex_q.store_flag;
    assign ex_reg_load_flag = ex_q.reg_load_flag;
    assign ex_mem_load_flag = ex_q.mem_load_flag;
    assign fetch_err        = fetch_err_q;
    assign instr_count      = cnt_q;

endmodule

// File: doc/ie_fetch_sequencer.md
Name: ie_fetch_sequencer

Overview:
- Execute-side partner of instr_fetch.
- Owns the PC and drives the fetch request handshake: pulses ie_ready, then waits for instr_valid to fall and rise again.
- Captures the decoded instruction fields and hands them downstream to the execute datapath over a valid/ready channel.
- Computes the next PC from the fetch-supplied pc_to_ie or from a pending branch redirect; adds a fetch-timeout watchdog and a retired-instruction count.

Parameters:
- RESET_PC, 16'h0100, PC value loaded on reset.
- TIMEOUT_CYCLES, 64, max cycles spent in WAIT_LOW or WAIT_HIGH before error.
- CNT_W, 32, width of instr_count.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- run  in  1  enable continuous sequencing
- if_pc_to_ie  in  16  PC following the fetched instruction
- if_addr_to_ie  in  16  operand/effective address from fetch
- if_new_op  in  8  opcode
- if_alu_op  in  4  ALU operation
- if_imm_mode  in  1  immediate operand flag
- if_store_flag  in  3  store target
- if_reg_load_flag  in  2  register load target
- if_mem_load_flag  in  1  memory load flag
- if_instr_valid  in  1  fetch result valid
- ie_ready  out  1  fetch start pulse
- pc_from_ie  out  16  PC presented to fetch
- ex_valid  out  1  instruction available downstream
- ex_ready  in  1  downstream accepts
- ex_op  out  8  latched if_new_op
- ex_alu_op  out  4  latched if_alu_op
- ex_addr  out  16  latched if_addr_to_ie
- ex_imm_mode  out  1  latched if_imm_mode
- ex_store_flag  out  3  latched if_store_flag
- ex_reg_load_flag  out  2  latched if_reg_load_flag
- ex_mem_load_flag  out  1  latched if_mem_load_flag
- redirect_valid  in  1  branch redirect strobe
- redirect_pc  in  16  redirect target
- fetch_err  out  1  sticky timeout flag
- instr_count  out  CNT_W  retired instruction count

Behaviour:
- Reset (rst low, async):
  - state=IDLE, pc_from_ie=RESET_PC.
  - ie_ready, ex_valid and fetch_err cleared; all ex_* fields 0.
  - instr_count=0, redirect pending cleared, watchdog counter 0.
- IDLE: ie_ready=0. run=1 -> ISSUE.
- ISSUE: ie_ready=1 for exactly one cycle, with pc_from_ie stable. Watchdog cleared. -> WAIT_LOW.
- WAIT_LOW:
  - if_instr_valid=0 -> WAIT_HIGH.
  - Otherwise watchdog increments; at TIMEOUT_CYCLES -> set fetch_err, go to IDLE.
- WAIT_HIGH:
  - if_instr_valid=1 -> latch all if_* fields into ex_* and if_pc_to_ie into an internal next_pc; ex_valid=1 next cycle; -> DISPATCH.
  - Same timeout rule as WAIT_LOW; watchdog cleared on entry.
- DISPATCH:
  - ex_valid and ex_* held stable until ex_ready=1.
  - On handshake, same edge:
    - ex_valid=0.
    - pc_from_ie <= redirect pending ? redirect target : next_pc.
    - Redirect pending cleared.
    - instr_count++ (wraps at 2^CNT_W).
  - Next state: run=1 -> ISSUE, else IDLE.
  - ex_ready while ex_valid=0 is ignored.
- Redirect:
  - redirect_valid is sampled in any state and stores redirect_pc as pending; a later redirect overwrites an earlier one.
  - redirect_valid coincident with the DISPATCH handshake applies to that PC update.
  - Redirect in IDLE updates pc_from_ie directly on the next edge.
- Latency: fastest path from ISSUE to ex_valid=1 is 3 cycles (ISSUE, WAIT_LOW, WAIT_HIGH capture). Back-to-back throughput is one instruction per 4 cycles plus fetch latency.
- run deasserted mid-fetch: the current instruction completes through DISPATCH, then the block goes to IDLE.
- fetch_err stays set until reset; sequencing may restart via run while it is set.
- pc_from_ie changes only at reset, at the DISPATCH handshake, or on a redirect in IDLE.

Decomposition:
- ie_defs gains:
  - typedef enum seq_state_t {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, DISPATCH}.
  - localparams PC_W=16, OP_W=8, ALU_OP_W=4.
  - A packed struct ex_instr_t bundling the ex_* fields.
- One sub-module, fetch_watchdog: counter with clear, enable and timeout output, parameterised by TIMEOUT_CYCLES.

Test Plan:
1. Reset, then run=1 with the fetch model returning op 8'hA9, addr 16'h0101, pc_to_ie 16'h0102:
   - ie_ready pulses once with pc_from_ie=16'h0100.
   - ex_op=8'hA9 and ex_valid=1; after ex_ready, pc_from_ie=16'h0102 and instr_count=1.
2. ex_ready held low for 5 cycles:
   - ex_valid and ex_op stay stable throughout.
   - No second ie_ready pulse until the handshake completes.
3. redirect_valid with redirect_pc=16'h0200 during WAIT_HIGH:
   - After the handshake, pc_from_ie=16'h0200, not pc_to_ie.
   - The next ie_ready pulse presents 16'h0200.
4. Fetch model keeps instr_valid low for 70 cycles:
   - fetch_err=1 after 64 cycles in WAIT_HIGH, state returns to IDLE, ex_valid stays 0.
5. rst pulled low during DISPATCH:
   - ex_valid=0, pc_from_ie=16'h0100 and instr_count=0 immediately, without waiting for a clock edge.
6. run=1 for 10 back-to-back instructions, then run dropped during fetch #10:
   - instr_count=10, state ends in IDLE with no further ie_ready.
